// File: rtl/riscv_core_dpath_vec_wb_seq.sv
// Writeback sequencer for vector ALU results. It writes a vector result into the
// vector RF one element at a time, and a reduction result into the scalar RF as one write.
module riscv_core_dpath_vec_wb_seq #(
    parameter int NELEM = 8,
    parameter int EW    = 32,
    parameter int RAW   = 5,
    localparam int EIW  = $clog2(NELEM)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [NELEM*EW-1:0] in_data,
    input  logic [NELEM-1:0]    in_vm,
    input  logic [3:0]          in_vl,
    input  logic                in_red,
    input  logic [RAW-1:0]      in_rd,
    output logic                rf_wen,
    input  logic                rf_wrdy,
    output logic [RAW-1:0]      rf_waddr,
    output logic [EIW-1:0]      rf_welem,
    output logic [EW-1:0]       rf_wdata,
    output logic                sc_wen,
    output logic [RAW-1:0]      sc_waddr,
    output logic [EW-1:0]       sc_wdata,
    output logic                busy,
    output logic                done
);

    // Handshake: a result transfers on a rising edge where in_val and in_rdy are both 1;
    // a vector element transfers on a rising edge where rf_wen and rf_wrdy are both 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VEC  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [NELEM*EW-1:0]   data_q;
    logic [RAW-1:0]        rd_q;
    logic [NELEM-1:0]      em_q;

    logic                  accept;
    logic [NELEM-1:0]      len_mask;
    logic [NELEM-1:0]      em_in;
    logic [NELEM-1:0]      em_clr;
    logic [EIW-1:0]        sel_idx;
    logic                  wr_fire;

    assign accept  = (state_q == IDLE) && in_val;
    assign wr_fire = (state_q == VEC) && rf_wrdy;

    // vl values of NELEM and above leave every element enabled.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < NELEM; i++) begin
            len_mask[i] = ({28'd0, in_vl} > 32'(i));
        end
    end

    assign em_in  = in_vm & len_mask;
    assign em_clr = em_q & (em_q - NELEM'(1));

    // Scan from the top down so that the lowest set bit wins.
    always_comb begin
        sel_idx = '0;
        for (int i = NELEM - 1; i >= 0; i--) begin
            if (em_q[i]) begin
                sel_idx = EIW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_val) begin
                    if (in_red) begin
                        state_d = RED;
                    end else if (em_in != '0) begin
                        state_d = VEC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            VEC: begin
                if (rf_wrdy && (em_clr == '0)) begin
                    state_d = DONE;
                end
            end
            RED:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A reduction ignores vm/vl, so its mask is simply left empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            rd_q   <= '0;
            em_q   <= '0;
        end else if (accept) begin
            data_q <= in_data;
            rd_q   <= in_rd;
            em_q   <= in_red ? '0 : em_in;
        end else if (wr_fire) begin
            em_q   <= em_clr;
        end
    end

    always_comb begin
        in_rdy   = 1'b0;
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_welem = '0;
        rf_wdata = '0;
        sc_wen   = 1'b0;
        sc_waddr = '0;
        sc_wdata = '0;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        case (state_q)
            IDLE: in_rdy = 1'b1;
            VEC: begin
                rf_wen   = 1'b1;
                rf_waddr = rd_q;
                rf_welem = sel_idx;
                rf_wdata = data_q[sel_idx*EW +: EW];
            end
            RED: begin
                sc_wen   = 1'b1;
                sc_waddr = rd_q;
                sc_wdata = data_q[EW-1:0];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_core_dpath_vec_wb_seq.sv
// Directed bench for the vector writeback sequencer: expected writes and done pulses,
// each tagged with its cycle relative to accept, are queued and checked by a monitor.
module tb_riscv_core_dpath_vec_wb_seq;
  localparam int NELEM = 8;
  localparam int EW    = 32;
  localparam int RAW   = 5;
  localparam int W     = 2 + 8 + RAW + 3 + EW;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_val = 1'b0;
  logic                in_rdy;
  logic [NELEM*EW-1:0] in_data = '0;
  logic [NELEM-1:0]    in_vm = '0;
  logic [3:0]          in_vl = '0;
  logic                in_red = 1'b0;
  logic [RAW-1:0]      in_rd = '0;
  logic                rf_wen;
  logic                rf_wrdy = 1'b1;
  logic [RAW-1:0]      rf_waddr;
  logic [2:0]          rf_welem;
  logic [EW-1:0]       rf_wdata;
  logic                sc_wen;
  logic [RAW-1:0]      sc_waddr;
  logic [EW-1:0]       sc_wdata;
  logic                busy;
  logic                done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int wr_cnt = 0;
  logic [W-1:0] exp_q[$];

  riscv_core_dpath_vec_wb_seq #(.NELEM(NELEM), .EW(EW), .RAW(RAW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data), .in_vm(in_vm),
    .in_vl(in_vl), .in_red(in_red), .in_rd(in_rd),
    .rf_wen(rf_wen), .rf_wrdy(rf_wrdy), .rf_waddr(rf_waddr), .rf_welem(rf_welem),
    .rf_wdata(rf_wdata), .sc_wen(sc_wen), .sc_waddr(sc_waddr), .sc_wdata(sc_wdata),
    .busy(busy), .done(done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ev(input logic [1:0] k, input int rel,
                                      input logic [RAW-1:0] a, input logic [2:0] e,
                                      input logic [EW-1:0] d);
    logic [7:0] r;
    r = rel[7:0];
    return {k, r, a, e, d};
  endfunction

  task automatic exp_wr(input int rel, input logic [RAW-1:0] a, input logic [2:0] e,
                        input logic [EW-1:0] d);
    exp_q.push_back(ev(2'd1, rel, a, e, d));
  endtask

  task automatic exp_sc(input int rel, input logic [RAW-1:0] a, input logic [EW-1:0] d);
    exp_q.push_back(ev(2'd2, rel, a, 3'd0, d));
  endtask

  task automatic exp_done(input int rel);
    exp_q.push_back(ev(2'd3, rel, '0, 3'd0, '0));
  endtask

  // driver tasks
  task automatic send(input logic [NELEM*EW-1:0] data, input logic [NELEM-1:0] vm,
                      input logic [3:0] vl, input logic red, input logic [RAW-1:0] rd);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!in_rdy) begin
      errors++;
      $display("FAIL accept_wait: in_rdy=%0b required 1", in_rdy);
    end
    acc_cyc = cyc;
    in_data = data;
    in_vm   = vm;
    in_vl   = vl;
    in_red  = red;
    in_rd   = rd;
    in_val  = 1'b1;
    @(posedge clk);
    #1;
    in_val  = 1'b0;
    in_data = {NELEM{32'hBAD0_BAD0}};
    in_vm   = '0;
    in_vl   = '0;
    in_red  = 1'b0;
    in_rd   = '0;
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_rdy_after_done: in_rdy=%0b required 1", name, in_rdy);
    end
  endtask

  task automatic check_quiet(input string name);
    logic [W+3:0] got;
    got = {rf_wen, rf_waddr, rf_welem, rf_wdata, sc_wen, sc_waddr, sc_wdata, busy, done,
           in_rdy};
    checks++;
    if (got !== {{(W+3){1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL %s: outputs=%h required only in_rdy set", name, got);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    logic [RAW+3+EW:0] held;
    logic hold_v;
    logic have;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        checks++;
        if (rf_wen && sc_wen) begin
          errors++;
          $display("FAIL both_wen: rf_wen=1 sc_wen=1 required exclusive");
        end
        checks++;
        if ((!rf_wen && {rf_waddr, rf_welem, rf_wdata} != '0) ||
            (!sc_wen && {sc_waddr, sc_wdata} != '0)) begin
          errors++;
          $display("FAIL inactive_zero: rf=%h sc=%h required 0",
                   {rf_waddr, rf_welem, rf_wdata}, {sc_waddr, sc_wdata});
        end
        checks++;
        if (busy !== !in_rdy) begin
          errors++;
          $display("FAIL busy_rdy: busy=%0b in_rdy=%0b required opposite", busy, in_rdy);
        end
        if (hold_v) begin
          checks++;
          if ({rf_wen, rf_waddr, rf_welem, rf_wdata} !== held) begin
            errors++;
            $display("FAIL stall_stable: rf=%h required %h",
                     {rf_wen, rf_waddr, rf_welem, rf_wdata}, held);
          end
        end
        hold_v = rf_wen && !rf_wrdy;
        held = {rf_wen, rf_waddr, rf_welem, rf_wdata};
        have = 1'b0;
        got = '0;
        if (rf_wen && rf_wrdy) begin
          got = ev(2'd1, cyc - acc_cyc, rf_waddr, rf_welem, rf_wdata);
          have = 1'b1;
          wr_cnt++;
        end else if (sc_wen) begin
          got = ev(2'd2, cyc - acc_cyc, sc_waddr, 3'd0, sc_wdata);
          have = 1'b1;
        end else if (done) begin
          got = ev(2'd3, cyc - acc_cyc, '0, 3'd0, '0);
          have = 1'b1;
        end
        if (have) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got=%h required none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL event: got=%h required %h", got, want);
            end
          end
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  function automatic logic [NELEM*EW-1:0] pack(input logic [EW-1:0] base);
    logic [NELEM*EW-1:0] v;
    for (int i = 0; i < NELEM; i++) v[i*EW +: EW] = base + EW'(i);
    return v;
  endfunction

  task automatic run_t1(input string name);
    for (int i = 0; i < 8; i++) exp_wr(i + 1, 5'd3, 3'(i), 32'(i + 1));
    exp_done(9);
    send(pack(32'd1), 8'hFF, 4'd8, 1'b0, 5'd3);
    wait_drain(name, 40);
  endtask

  // stimulus
  initial begin
    logic [NELEM*EW-1:0] d;
    int guard;
    #12;
    check_quiet("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_t1("t1");

    // T2: vm=A5, vl=6 -> elems 0,2,5
    exp_wr(1, 5'd9, 3'd0, 32'hA0);
    exp_wr(2, 5'd9, 3'd2, 32'hA2);
    exp_wr(3, 5'd9, 3'd5, 32'hA5);
    exp_done(4);
    send(pack(32'hA0), 8'b1010_0101, 4'd6, 1'b0, 5'd9);
    wait_drain("t2", 40);

    // T3: stall three cycles on elem 1
    exp_wr(1, 5'd12, 3'd0, 32'h1000_0000);
    exp_wr(5, 5'd12, 3'd1, 32'h1000_0001);
    exp_wr(6, 5'd12, 3'd2, 32'h1000_0002);
    exp_wr(7, 5'd12, 3'd3, 32'h1000_0003);
    exp_done(8);
    send(pack(32'h1000_0000), 8'h0F, 4'd4, 1'b0, 5'd12);
    @(posedge clk);
    #1 rf_wrdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rf_wrdy = 1'b1;
    wait_drain("t3", 40);

    // T4: reduction, element 0 only
    d = {NELEM{32'hDEAD_BEEF}};
    d[EW-1:0] = 32'h0000_002A;
    exp_sc(1, 5'd7, 32'd42);
    exp_done(2);
    send(d, 8'h00, 4'd0, 1'b1, 5'd7);
    wait_drain("t4", 20);

    // T5: vl=0 -> empty mask
    exp_done(1);
    send(pack(32'h50), 8'hFF, 4'd0, 1'b0, 5'd1);
    wait_drain("t5", 20);

    // vl above 8 behaves as 8
    exp_wr(1, 5'd30, 3'd0, 32'hC0);
    exp_wr(2, 5'd30, 3'd7, 32'hC7);
    exp_done(3);
    send(pack(32'hC0), 8'h81, 4'd12, 1'b0, 5'd30);
    wait_drain("vl_over", 20);

    // T6: reset after the third write
    wr_cnt = 0;
    for (int i = 0; i < 3; i++) exp_wr(i + 1, 5'd4, 3'(i), 32'(i + 1));
    send(pack(32'd1), 8'hFF, 4'd8, 1'b0, 5'd4);
    guard = 0;
    while (wr_cnt < 3 && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    #2 reset_n = 1'b0;
    #1;
    check_quiet("t6_reset_outputs");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t6_pending: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    run_t1("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end
endmodule
